slc3_mem_arbiter: RTL
=====================

// Module: slc3_mem_arbiter
// PURPOSE
// Sequences all accesses to the external 16-bit SRAM for the SLC-3 system. Two requesters share it:
// the CPU datapath (MAR/MDR port) and the program loader port. Generates CE/UB/LB/OE/WE timing and
// owns the tristate Data bus. Decodes the I/O address: reads return switches S, writes update hex_out.
// Sits in the toplevel between the slc3 core, the loader and the SRAM pins.
// PARAMETERS
// WAIT_CYCLES  2        SRAM access cycles per transfer; legal range 1..7
// IO_ADDR      16'hFFFF CPU-port address mapped to switches (read) / hex_out (write)
// PORTS
// Clk        in   1   system clock, 50 MHz
// Reset      in   1   asynchronous, active-low reset
// cpu_req    in   1   CPU request; held high until cpu_rdy
// cpu_we     in   1   1 = write, 0 = read
// cpu_addr   in   16  word address (MAR)
// cpu_wdata  in   16  write data (MDR)
// cpu_rdata  out  16  read data; valid while cpu_rdy = 1, then held
// cpu_rdy    out  1   one-cycle completion pulse
// ldr_req / ldr_we / ldr_addr / ldr_wdata / ldr_rdata / ldr_rdy: same as cpu_*; no I/O decode
// S          in   16  switch inputs
// hex_out    out  16  value shown on the hex displays
// busy       out  1   1 whenever the FSM is not in IDLE
// ADDR       out  20  SRAM address = {4'h0, latched addr}
// Data       inout 16 SRAM data bus; driven only in WRITE and WHOLD
// CE,UB,LB,OE,WE out 1 SRAM controls, active-low
// BEHAVIOUR
// - Reset (asynchronous, takes effect mid-access): state IDLE, CE=UB=LB=OE=WE=1, Data=Z, ADDR=0,
//   rdy=0, rdata=0, hex_out=0, busy=0, last_gnt=LDR (the CPU wins the first tie).
// - States: IDLE, READ, WRITE, WHOLD, DONE. Counter cnt is 3 bits.
// - IDLE: sample requests; round-robin -> if both request, grant the one not in last_gnt, else grant
//   the sole requester. Latch addr/we/wdata/id, set cnt=WAIT_CYCLES-1, update last_gnt.
//   CPU read at IO_ADDR: no SRAM cycle; cpu_rdata<=S, go to DONE.
//   CPU write at IO_ADDR: hex_out<=cpu_wdata, go to DONE.
//   Otherwise go to READ or WRITE.
// - READ: CE=UB=LB=OE=0. cnt decrements; at cnt==0, latch Data into the granted rdata, go to DONE.
// - WRITE: CE=UB=LB=WE=0, OE=1, Data driven. At cnt==0, go to WHOLD.
// - WHOLD: WE=1, CE=0, Data still driven (hold time), then go to DONE.
// - DONE: granted rdy=1 for exactly one cycle; Data=Z, controls inactive; next state IDLE.
//   IDLE never grants in the same cycle as DONE, so one turnaround cycle is guaranteed.
// - Latency from accept in IDLE at cycle N to rdy: SRAM read N+WAIT_CYCLES+1;
//   SRAM write N+WAIT_CYCLES+2; I/O access N+1.
// - The non-granted requester waits; its req stays high and is re-evaluated in the next IDLE.
// - If req drops before rdy, the access still completes and rdy still pulses.
// - rdata of the non-granted port is unchanged.
// - Address inputs and wdata are sampled only in IDLE; later changes do not affect a running access.
// - The loader port never decodes IO_ADDR; it accesses SRAM word 0xFFFF.
// STRUCTURE
// - Package slc3_mem_pkg: state_t enum {IDLE,READ,WRITE,WHOLD,DONE}, req_id_t enum {CPU,LDR},
//   default IO_ADDR constant.
// - Sub-module mem_rr_arbiter: 2-input round-robin, inputs req[1:0] + accept strobe,
//   outputs gnt id + valid; owns last_gnt.
// - Top: FSM, cnt, latches, tristate assign Data = drive ? wdata_q : 16'hZZZZ.
// TESTING
// - Reset hold, then release -> all SRAM controls 1, Data=Z, busy=0, hex_out=0.
// - CPU read 0x0031 with the SRAM model holding 0x1234, WAIT_CYCLES=2 -> OE low for 2 cycles;
//   cpu_rdy at accept+3 with cpu_rdata=0x1234.
// - CPU write 0x0040 <- 0xBEEF -> WE low 2 cycles, Data held through WHOLD;
//   a subsequent read of 0x0040 returns 0xBEEF.
// - CPU and ldr request in the same cycle twice -> grants CPU then LDR;
//   ldr_rdy follows cpu_rdy after IDLE turnaround.
// - S=0x0075, CPU read IO_ADDR -> cpu_rdy at accept+1, rdata=0x0075, CE stays 1.
//   CPU write IO_ADDR 0x00A5 -> hex_out=0x00A5.
// - Reset asserted during WRITE -> WE/CE go 1 and Data=Z immediately;
//   after release, the FSM is in IDLE with no rdy pulse.

Source files
------------

// File: rtl/slc3_mem_pkg.sv
// rtl/slc3_mem_pkg.sv - shared types and constants for the SLC-3 SRAM arbiter
package slc3_mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    WHOLD = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic {
    CPU = 1'b0,
    LDR = 1'b1
  } req_id_t;

  localparam logic [15:0] DEFAULT_IO_ADDR = 16'hFFFF;

endpackage

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - two-input round-robin grant selection with last-grant memory
module mem_rr_arbiter
  import slc3_mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,     // bit 0 = CPU, bit 1 = loader
  input  logic       accept_i,  // grant is taken this cycle
  output req_id_t    gnt_o,
  output logic       valid_o
);

  req_id_t last_gnt_q, last_gnt_d;

  // On a tie the port that did not win last time is chosen; a lone requester always wins
  always_comb begin
    valid_o    = |req_i;
    gnt_o      = CPU;
    last_gnt_d = last_gnt_q;
    if (req_i == 2'b11) begin
      gnt_o = (last_gnt_q == CPU) ? LDR : CPU;
    end else if (req_i[1]) begin
      gnt_o = LDR;
    end
    if (accept_i && valid_o) begin
      last_gnt_d = gnt_o;
    end
  end

  // Reset to LDR so the CPU wins the first tie
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_gnt_q <= LDR;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/slc3_mem_arbiter.sv
// rtl/slc3_mem_arbiter.sv - SRAM access sequencer shared by the SLC-3 CPU and the program loader
module slc3_mem_arbiter
  import slc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = DEFAULT_IO_ADDR
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_rdy,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [15:0] ldr_addr,
  input  logic [15:0] ldr_wdata,
  output logic [15:0] ldr_rdata,
  output logic        ldr_rdy,
  input  logic [15:0] S,
  output logic [15:0] hex_out,
  output logic        busy,
  output logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE
);

  localparam logic [2:0] CNT_INIT = 3'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  req_id_t     id_q, id_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] ldr_rdata_q, ldr_rdata_d;
  logic [15:0] hex_q, hex_d;

  req_id_t     gnt_id;
  logic        gnt_valid;
  logic        accept;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        drive;

  mem_rr_arbiter u_rr (
    .clk_i    (Clk),
    .rst_ni   (Reset),
    .req_i    ({ldr_req, cpu_req}),
    .accept_i (accept),
    .gnt_o    (gnt_id),
    .valid_o  (gnt_valid)
  );

  assign sel_we    = (gnt_id == CPU) ? cpu_we    : ldr_we;
  assign sel_addr  = (gnt_id == CPU) ? cpu_addr  : ldr_addr;
  assign sel_wdata = (gnt_id == CPU) ? cpu_wdata : ldr_wdata;

  // Next-state and latch updates; I/O decode applies to the CPU port only
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    hex_d       = hex_q;
    accept      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          accept  = 1'b1;
          id_d    = gnt_id;
          cnt_d   = CNT_INIT;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          if ((gnt_id == CPU) && (cpu_addr == IO_ADDR)) begin
            if (cpu_we) hex_d = cpu_wdata;
            else        cpu_rdata_d = S;
            state_d = DONE;
          end else begin
            state_d = sel_we ? WRITE : READ;
          end
        end
      end
      READ: begin
        if (cnt_q == 3'd0) begin
          if (id_q == CPU) cpu_rdata_d = Data;
          else             ldr_rdata_d = Data;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      WRITE: begin
        if (cnt_q == 3'd0) state_d = WHOLD;
        else               cnt_d = cnt_q - 3'd1;
      end
      WHOLD:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latches; an asynchronous reset aborts any access in flight
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      id_q        <= CPU;
      cnt_q       <= 3'd0;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      cpu_rdata_q <= 16'h0000;
      ldr_rdata_q <= 16'h0000;
      hex_q       <= 16'h0000;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
      hex_q       <= hex_d;
    end
  end

  // SRAM strobes decoded from state so reset releases them without waiting for a clock
  always_comb begin
    CE    = 1'b1;
    UB    = 1'b1;
    LB    = 1'b1;
    OE    = 1'b1;
    WE    = 1'b1;
    drive = 1'b0;
    unique case (state_q)
      READ:  begin CE = 1'b0; UB = 1'b0; LB = 1'b0; OE = 1'b0; end
      WRITE: begin CE = 1'b0; UB = 1'b0; LB = 1'b0; WE = 1'b0; drive = 1'b1; end
      WHOLD: begin CE = 1'b0; UB = 1'b0; LB = 1'b0; drive = 1'b1; end
      default: ;
    endcase
  end

  assign Data      = drive ? wdata_q : 16'hZZZZ;
  assign ADDR      = {4'h0, addr_q};
  assign busy      = (state_q != IDLE);
  assign cpu_rdy   = (state_q == DONE) && (id_q == CPU);
  assign ldr_rdy   = (state_q == DONE) && (id_q == LDR);
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign hex_out   = hex_q;

endmodule
